// File: rtl/tlk2711_rx_cmd.sv
// Receive-side DMA command engine: issues S2MM write commands into a DDR slot ring,
// checks write status, counts completed packets and pulses an interrupt per packet.
module tlk2711_rx_cmd #(
    parameter int BTT_W      = 23,
    parameter int SLOT_CNT_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_soft_rst,
    input  logic [31:0] i_reg_wdata,
    input  logic [11:0] i_reg_waddr,
    input  logic        i_reg_wen,
    input  logic        i_reg_ren,
    input  logic [11:0] i_reg_raddr,
    output logic [31:0] o_reg_rdata,
    output logic        o_reg_valid,
    output logic [71:0] o_dma_wrcmd_data,
    output logic        o_dma_wrcmd_valid,
    input  logic        i_dma_wrcmd_ready,
    input  logic [7:0]  i_dma_wrsts_data,
    input  logic        i_dma_wrsts_valid,
    output logic        o_rx_armed,
    output logic        o_irq
);

    localparam logic [11:0] ADDR_CTR       = 12'h004;
    localparam logic [11:0] ADDR_DDR_ADDR  = 12'h010;
    localparam logic [11:0] ADDR_SLOT_SIZE = 12'h014;
    localparam logic [11:0] ADDR_SLOT_NUM  = 12'h018;
    localparam logic [11:0] ADDR_STATUS    = 12'h01C;
    localparam logic [11:0] ADDR_PKT_CNT   = 12'h020;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_enable;
    logic [31:0]           r_base;
    logic [BTT_W-1:0]      r_slot_size;
    logic [SLOT_CNT_W-1:0] r_slot_num;

    // Working copies of the ring geometry, captured when a run starts.
    logic [31:0]           r_act_base;
    logic [BTT_W-1:0]      r_act_size;
    logic [SLOT_CNT_W-1:0] r_act_num;

    logic [31:0]           r_cur_addr;
    logic [SLOT_CNT_W-1:0] r_slot_idx;
    logic [SLOT_CNT_W-1:0] r_pkt_cnt;
    logic [3:0]            r_tag;
    logic                  r_err;
    logic [7:0]            r_last_sts;
    logic                  r_irq;
    logic [31:0]           r_reg_rdata;
    logic                  r_reg_valid;

    logic                  w_clear_err;
    logic                  w_sts_ok;
    logic                  w_sts_pass;
    logic                  w_sts_fail;
    logic                  w_last_slot;
    logic                  w_start;
    logic [22:0]           w_btt;

    assign w_clear_err = i_reg_wen && (i_reg_waddr == ADDR_CTR) && i_reg_wdata[1];
    assign w_sts_ok    = i_dma_wrsts_data[7] && (i_dma_wrsts_data[6:4] == 3'd0)
                         && (i_dma_wrsts_data[3:0] == r_tag);
    assign w_sts_pass  = (r_state == ST_WAIT) && i_dma_wrsts_valid && w_sts_ok;
    assign w_sts_fail  = (r_state == ST_WAIT) && i_dma_wrsts_valid && !w_sts_ok;
    // A slot count of zero behaves as a single-slot ring.
    assign w_last_slot = (r_act_num == '0) || (r_slot_idx >= (r_act_num - SLOT_CNT_W'(1)));
    assign w_start     = (r_state == ST_IDLE) && (w_next_state == ST_ISSUE);
    assign w_btt       = 23'(r_act_size);

    assign o_dma_wrcmd_data = {4'd0, r_tag, r_cur_addr, 1'b0, 1'b1, 6'd0, 1'b1, w_btt};
    assign o_irq            = r_irq;
    assign o_reg_rdata      = r_reg_rdata;
    assign o_reg_valid      = r_reg_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else if (i_soft_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state      = r_state;
        o_dma_wrcmd_valid = 1'b0;
        o_rx_armed        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_enable && !r_err) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                o_dma_wrcmd_valid = 1'b1;
                if (i_dma_wrcmd_ready) w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                o_rx_armed = 1'b1;
                if (w_sts_pass)      w_next_state = r_enable ? ST_ISSUE : ST_IDLE;
                else if (w_sts_fail) w_next_state = ST_ERR;
            end
            ST_ERR: begin
                if (w_clear_err) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_enable    <= 1'b0;
            r_base      <= '0;
            r_slot_size <= '0;
            r_slot_num  <= '0;
        end else if (i_soft_rst) begin
            r_enable    <= 1'b0;
            r_base      <= '0;
            r_slot_size <= '0;
            r_slot_num  <= '0;
        end else if (i_reg_wen) begin
            case (i_reg_waddr)
                ADDR_CTR:       r_enable    <= i_reg_wdata[0];
                ADDR_DDR_ADDR:  r_base      <= i_reg_wdata;
                ADDR_SLOT_SIZE: r_slot_size <= i_reg_wdata[BTT_W-1:0];
                ADDR_SLOT_NUM:  r_slot_num  <= i_reg_wdata[SLOT_CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_base <= '0;
            r_act_size <= '0;
            r_act_num  <= '0;
            r_cur_addr <= '0;
            r_slot_idx <= '0;
            r_pkt_cnt  <= '0;
            r_tag      <= '0;
            r_err      <= 1'b0;
            r_last_sts <= '0;
            r_irq      <= 1'b0;
        end else if (i_soft_rst) begin
            r_act_base <= '0;
            r_act_size <= '0;
            r_act_num  <= '0;
            r_cur_addr <= '0;
            r_slot_idx <= '0;
            r_pkt_cnt  <= '0;
            r_tag      <= '0;
            r_err      <= 1'b0;
            r_last_sts <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= w_sts_pass;
            if (w_start) begin
                r_act_base <= r_base;
                r_act_size <= r_slot_size;
                r_act_num  <= r_slot_num;
                r_cur_addr <= r_base;
            end
            if (w_sts_pass) begin
                r_pkt_cnt  <= r_pkt_cnt + SLOT_CNT_W'(1);
                r_tag      <= r_tag + 4'd1;
                r_last_sts <= i_dma_wrsts_data;
                if (w_last_slot) begin
                    r_slot_idx <= '0;
                    r_cur_addr <= r_act_base;
                end else begin
                    r_slot_idx <= r_slot_idx + SLOT_CNT_W'(1);
                    r_cur_addr <= r_cur_addr + 32'(r_act_size);
                end
            end
            if (w_sts_fail) begin
                r_err      <= 1'b1;
                r_last_sts <= i_dma_wrsts_data;
            end
            if ((r_state == ST_ERR) && w_clear_err) r_err <= 1'b0;
        end
    end

    // Reads see pre-edge register values, so a same-cycle write is not visible yet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_reg_rdata <= '0;
            r_reg_valid <= 1'b0;
        end else if (i_soft_rst) begin
            r_reg_rdata <= '0;
            r_reg_valid <= 1'b0;
        end else begin
            r_reg_valid <= i_reg_ren;
            r_reg_rdata <= '0;
            if (i_reg_ren) begin
                case (i_reg_raddr)
                    ADDR_DDR_ADDR:  r_reg_rdata <= r_base;
                    ADDR_SLOT_SIZE: r_reg_rdata <= 32'(r_slot_size);
                    ADDR_SLOT_NUM:  r_reg_rdata <= 32'(r_slot_num);
                    ADDR_STATUS:    r_reg_rdata <= {8'd0, r_last_sts, 13'd0, r_err, r_state};
                    ADDR_PKT_CNT:   r_reg_rdata <= 32'(r_pkt_cnt);
                    default:        r_reg_rdata <= '0;
                endcase
            end
        end
    end

endmodule
